// File: rtl/spi_sub.sv
// spi_sub: SPI mode-0 subordinate bridging 44-bit command frames onto a 32-bit memory bus.
// Latency: strobe one sclk after the last command bit; resp[43] on miso 3 rising edges after it.
// Backpressure: none; the host paces everything through sclk, and cs_n high aborts at any point.
//
// Ports:
//   sclk    - SPI clock. Rising edge drives all state; falling edge launches miso.
//   rst_n   - asynchronous active-low reset
//   cs_n    - chip select, active low. Sampled high on a rising edge, it returns the block to IDLE.
//   mosi    - serial command data, MSB first, sampled on rising sclk
//   miso    - serial response data, MSB first, changes on falling sclk. It is 0 outside TX.
//   r_en    - one-cycle memory read strobe (op 00)
//   w_en    - one-cycle memory write strobe (op 01)
//   addr    - memory address. It holds its value between frames.
//   data_o  - memory write data. It holds its value between frames.
//   data_i  - memory read data. It is combinationally valid while r_en is high.
//
// Frame layout (MSB first): {op[1:0], addr[9:0], data[31:0]}.
// Op 00 reads, op 01 writes, and ops 10/11 only echo the frame.
// The response is {op, addr, data_i} for a read. For any other op it is the received frame.

module spi_sub (
  input  logic        sclk,
  input  logic        rst_n,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        r_en,
  output logic        w_en,
  output logic [9:0]  addr,
  output logic [31:0] data_o,
  input  logic [31:0] data_i
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [5:0] LAST_BIT = 6'd43;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RX   = 3'd1,
    EXEC = 3'd2,
    WAIT = 3'd3,
    TX   = 3'd4
  } state_e;

  state_e      state_q;
  logic [5:0]  cnt_q;      // RX: bits captured so far; TX: index of the bit on miso
  logic [43:0] shift_q;    // incoming frame, still intact during EXEC
  logic [43:0] resp_q;     // response frame, loaded on the edge that closes EXEC
  logic        r_en_q;
  logic        w_en_q;
  logic [9:0]  addr_q;
  logic [31:0] data_q;
  logic        miso_q;

  // The frame as it stands once the current mosi bit is shifted in.
  // On the 44th RX edge this value is the complete command.
  logic [43:0] frame_d;
  logic [1:0]  op_d;

  always_comb begin
    frame_d = {shift_q[42:0], mosi};
    op_d    = frame_d[43:42];
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      resp_q  <= '0;
      r_en_q  <= 1'b0;
      w_en_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (cs_n) begin
      // Deselect drops any partial frame. A strobe that is high on this edge
      // has already been seen by the memory, so that access still completes.
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      r_en_q  <= 1'b0;
      w_en_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // The first command bit lands on the selecting edge itself.
          shift_q <= {43'd0, mosi};
          cnt_q   <= 6'd1;
          state_q <= RX;
        end

        RX: begin
          shift_q <= frame_d;
          if (cnt_q == LAST_BIT) begin
            addr_q  <= frame_d[41:32];
            data_q  <= frame_d[31:0];
            w_en_q  <= (op_d == OP_WRITE);
            r_en_q  <= (op_d == OP_READ);
            cnt_q   <= '0;
            state_q <= EXEC;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end

        EXEC: begin
          // The read data is sampled on the same edge that ends the strobe.
          if (r_en_q) begin
            resp_q <= {shift_q[43:42], addr_q, data_i};
          end else begin
            resp_q <= shift_q;
          end
          r_en_q  <= 1'b0;
          w_en_q  <= 1'b0;
          state_q <= WAIT;
        end

        WAIT: begin
          cnt_q   <= LAST_BIT;
          state_q <= TX;
        end

        TX: begin
          if (cnt_q == 6'd0) begin
            // cs_n can stay low here. The next edge is bit 43 of a new frame.
            cnt_q   <= '0;
            state_q <= RX;
          end else begin
            cnt_q <= cnt_q - 6'd1;
          end
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          r_en_q  <= 1'b0;
          w_en_q  <= 1'b0;
        end
      endcase
    end
  end

  // Launch miso on the falling edge so that it is stable by the host's rising-edge sample.
  always_ff @(negedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      miso_q <= 1'b0;
    end else if (state_q == TX) begin
      miso_q <= resp_q[cnt_q];
    end else begin
      miso_q <= 1'b0;
    end
  end

  assign miso   = miso_q;
  assign r_en   = r_en_q;
  assign w_en   = w_en_q;
  assign addr   = addr_q;
  assign data_o = data_q;

endmodule

// File: tb/tb_spi_sub.sv
// tb_spi_sub: directed bench for spi_sub with a behavioural RAM on the memory bus.
// Latency: the bench samples 1 ns after every rising sclk edge.
// Backpressure: none; the bench drives cs_n and mosi directly, one bit per cycle.

module tb_spi_sub;

  logic        sclk;
  logic        rst_n;
  logic        cs_n;
  logic        mosi;
  logic        miso;
  logic        r_en;
  logic        w_en;
  logic [9:0]  addr;
  logic [31:0] data_o;
  logic [31:0] data_i;

  int n_tests;
  int n_fail;

  logic [31:0] mem [0:1023];

  spi_sub dut (
    .sclk   (sclk),
    .rst_n  (rst_n),
    .cs_n   (cs_n),
    .mosi   (mosi),
    .miso   (miso),
    .r_en   (r_en),
    .w_en   (w_en),
    .addr   (addr),
    .data_o (data_o),
    .data_i (data_i)
  );

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  // RAM: combinational read while r_en is high, synchronous write.
  always @(posedge sclk) begin
    if (w_en) mem[addr] <= data_o;
  end
  assign data_i = r_en ? mem[addr] : 32'd0;

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Shift one full frame in, check the bus strobe, then collect the 44 response bits.
  // On return the bench stands just after the rising edge that sampled resp[0].
  task automatic run_frame(input string tag, input logic [43:0] f,
                           input logic exp_w, input logic exp_r,
                           input logic [43:0] exp_resp);
    logic [43:0] got;
    logic        leak;
    got  = '0;
    leak = 1'b0;
    for (int i = 43; i >= 0; i--) begin
      cs_n = 1'b0;
      mosi = f[i];
      step();
      if (i > 0) leak = leak | r_en | w_en;
    end
    // R0 + 1ns: the EXEC cycle
    chk({tag, " w_en"},   {63'd0, w_en}, {63'd0, exp_w});
    chk({tag, " r_en"},   {63'd0, r_en}, {63'd0, exp_r});
    chk({tag, " addr"},   {54'd0, addr}, {54'd0, f[41:32]});
    chk({tag, " data_o"}, {32'd0, data_o}, {32'd0, f[31:0]});
    mosi = 1'b1;  // ignored from here on
    step();       // R0+1: the strobes drop
    chk({tag, " strobe_clr"}, {62'd0, r_en, w_en}, 64'd0);
    step();       // R0+2: TX entered, nothing launched yet
    chk({tag, " miso_wait"}, {63'd0, miso}, 64'd0);
    for (int k = 43; k >= 0; k--) begin
      mosi = ~mosi;
      step();     // R0+3+(43-k)
      got[k] = miso;
      leak   = leak | r_en | w_en;
    end
    chk({tag, " resp"}, {20'd0, got}, {20'd0, exp_resp});
    chk({tag, " no_extra_strobe"}, {63'd0, leak}, 64'd0);
  endtask

  logic [43:0] f_wr35, f_wr34, f_rd34, f_rd35, f_op10, f_part, f_wrf0, f_rdf0;
  logic        leak_abort;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;

    f_wr35 = {2'b01, 10'h035, 32'hCAFEBABE};
    f_wr34 = {2'b01, 10'h034, 32'hCAFEBABE};
    f_rd34 = {2'b00, 10'h034, 32'h00000000};
    f_rd35 = {2'b00, 10'h035, 32'h00000000};
    f_op10 = {2'b10, 10'h2AA, 32'h12345678};
    f_part = {2'b01, 10'h111, 32'hDEADBEEF};
    f_wrf0 = {2'b01, 10'h0F0, 32'h0BADF00D};
    f_rdf0 = {2'b00, 10'h0F0, 32'h00000000};

    rst_n = 1'b0;
    cs_n  = 1'b1;
    mosi  = 1'b0;
    #2;
    chk("rst miso",   {63'd0, miso}, 64'd0);
    chk("rst r_en",   {63'd0, r_en}, 64'd0);
    chk("rst w_en",   {63'd0, w_en}, 64'd0);
    chk("rst addr",   {54'd0, addr}, 64'd0);
    chk("rst data_o", {32'd0, data_o}, 64'd0);
    #20 rst_n = 1'b1;
    step();

    // Write 0x035, then write 0x034 back-to-back with cs_n held low.
    run_frame("wr35", f_wr35, 1'b1, 1'b0, {2'b01, 10'h035, 32'hCAFEBABE});
    run_frame("wr34", f_wr34, 1'b1, 1'b0, {2'b01, 10'h034, 32'hCAFEBABE});
    chk("mem34", {32'd0, mem[10'h034]}, {32'd0, 32'hCAFEBABE});

    // Deselect for 2 cycles, then read back both locations.
    cs_n = 1'b1;
    step();
    step();
    chk("desel miso", {63'd0, miso}, 64'd0);
    run_frame("rd34", f_rd34, 1'b0, 1'b1, {2'b00, 10'h034, 32'hCAFEBABE});
    run_frame("rd35", f_rd35, 1'b0, 1'b1, {2'b00, 10'h035, 32'hCAFEBABE});
    chk("mem34 kept", {32'd0, mem[10'h034]}, {32'd0, 32'hCAFEBABE});

    // An op-10 frame raises no strobe and is echoed back unchanged.
    run_frame("op10", f_op10, 1'b0, 1'b0, {2'b10, 10'h2AA, 32'h12345678});

    // Abort after 20 bits. Nothing may be decoded and the bus outputs must hold.
    cs_n = 1'b1;
    step();
    leak_abort = 1'b0;
    for (int i = 43; i >= 24; i--) begin
      cs_n = 1'b0;
      mosi = f_part[i];
      step();
      leak_abort = leak_abort | r_en | w_en;
    end
    cs_n = 1'b1;
    step();
    leak_abort = leak_abort | r_en | w_en;
    step();
    leak_abort = leak_abort | r_en | w_en;
    chk("abort strobe", {63'd0, leak_abort}, 64'd0);
    chk("abort addr",   {54'd0, addr}, {54'd0, 10'h2AA});
    chk("abort data_o", {32'd0, data_o}, {32'd0, 32'h12345678});
    chk("abort miso",   {63'd0, miso}, 64'd0);
    run_frame("wrf0", f_wrf0, 1'b1, 1'b0, {2'b01, 10'h0F0, 32'h0BADF00D});
    chk("mem111 untouched", {32'd0, mem[10'h111]}, 64'd0);
    chk("memf0", {32'd0, mem[10'h0F0]}, {32'd0, 32'h0BADF00D});

    // Reset in the middle of TX while miso carries resp[39] = addr bit 7 = 1.
    for (int i = 43; i >= 0; i--) begin
      cs_n = 1'b0;
      mosi = f_rdf0[i];
      step();
    end
    step();
    step();
    for (int k = 0; k < 5; k++) step();
    chk("midtx miso", {63'd0, miso}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst miso",   {63'd0, miso}, 64'd0);
    chk("midrst addr",   {54'd0, addr}, 64'd0);
    chk("midrst data_o", {32'd0, data_o}, 64'd0);
    chk("midrst strobe", {62'd0, r_en, w_en}, 64'd0);
    cs_n = 1'b1;
    #3 rst_n = 1'b1;
    step();
    step();
    chk("post rst miso", {63'd0, miso}, 64'd0);
    run_frame("rdf0", f_rdf0, 1'b0, 1'b1, {2'b00, 10'h0F0, 32'h0BADF00D});

    cs_n = 1'b1;
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
